// File: rtl/ttl74x259_sync_if.sv
// Bus bundle for the clocked 74x259 addressable latch: control/data inputs
// from the host side and the latched word, pointer and wrap pulse back.
interface ttl74x259_sync_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 3
);
   logic [ADDR_W-1:0] a;
   logic              d;
   logic              g_n;
   logic              clr_n;
   logic              auto_inc;
   logic [WIDTH-1:0]  q;
   logic [ADDR_W-1:0] ptr;
   logic              full;

   modport master (
      output a, d, g_n, clr_n, auto_inc,
      input  q, ptr, full
   );

   modport slave (
      input  a, d, g_n, clr_n, auto_inc,
      output q, ptr, full
   );
endinterface

// File: rtl/ttl74x259_sync.sv
// Clocked 74x259 addressable latch / 1-to-WIDTH demux with an auto-increment
// write pointer for shifting a serial bit stream into a parallel word.
module ttl74x259_sync #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 3
) (
   input logic              clk,
   input logic              rst,
   ttl74x259_sync_if.slave  bus
);
   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(WIDTH - 1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1'b1);
   localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
   localparam logic [WIDTH-1:0]  Q_ZERO   = {WIDTH{1'b0}};

   logic [WIDTH-1:0]  q_r;
   logic [ADDR_W-1:0] ptr_r;
   logic              full_r;

   logic [ADDR_W-1:0] sel_s;
   logic              wr_s;
   logic [WIDTH-1:0]  q_next_s;
   logic [ADDR_W-1:0] ptr_next_s;
   logic              full_next_s;

   // Latch select and pointer-advance strobe from the values present at the edge.
   always_comb begin
      sel_s = bus.a;
      wr_s  = 1'b0;
      if (bus.auto_inc) begin
         sel_s = ptr_r;
      end else begin
         sel_s = bus.a;
      end
      if (!bus.g_n && bus.auto_inc) begin
         wr_s = 1'b1;
      end else begin
         wr_s = 1'b0;
      end
   end

   // Next latch contents from the {g_n, clr_n} mode table.
   always_comb begin
      q_next_s = q_r;
      case ({bus.g_n, bus.clr_n})
         2'b11: q_next_s = q_r;
         2'b01: q_next_s[sel_s] = bus.d;
         2'b10: q_next_s = Q_ZERO;
         2'b00: begin
            q_next_s        = Q_ZERO;
            q_next_s[sel_s] = bus.d;
         end
         default: q_next_s = q_r;
      endcase
   end

   // Pointer advance with wrap; the wrap raises full for exactly one cycle.
   always_comb begin
      ptr_next_s  = ptr_r;
      full_next_s = 1'b0;
      if (bus.g_n && !bus.clr_n) begin
         ptr_next_s  = PTR_ZERO;
         full_next_s = 1'b0;
      end else if (wr_s) begin
         if (ptr_r == PTR_LAST) begin
            ptr_next_s  = PTR_ZERO;
            full_next_s = 1'b1;
         end else begin
            ptr_next_s  = ptr_r + PTR_ONE;
            full_next_s = 1'b0;
         end
      end else begin
         ptr_next_s  = ptr_r;
         full_next_s = 1'b0;
      end
   end

   // State registers; rst overrides every mode, including mid-sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r    <= Q_ZERO;
         ptr_r  <= PTR_ZERO;
         full_r <= 1'b0;
      end else begin
         q_r    <= q_next_s;
         ptr_r  <= ptr_next_s;
         full_r <= full_next_s;
      end
   end

   assign bus.q    = q_r;
   assign bus.ptr  = ptr_r;
   assign bus.full = full_r;
endmodule

// File: doc/ttl74x259_sync.md
Name: ttl74x259_sync

Overview:
- Clocked 8-bit addressable latch and 1-to-8 demultiplexer modelled on the 74x259 function table. It is the distribution-side counterpart of the 4-to-1 selector parts.
- Routes a single data bit `d` onto one of WIDTH stored output bits.
- Adds an internal auto-increment pointer so the CPU can shift a serial bit stream into a parallel control word (e.g. microcode strobe latch, flag register bank).

Parameters:
- WIDTH, 8, number of output latches; must be a power of two, at least 2.
- ADDR_W, 3, address width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- a  input  ADDR_W  external latch address (datasheet A/B/C).
- d  input  1  data bit to latch.
- g_n  input  1  enable, active low (datasheet G).
- clr_n  input  1  clear, active low (datasheet CLR).
- auto_inc  input  1  1 = use internal pointer instead of `a`.
- q  output  WIDTH  latched outputs (datasheet Q0..Q7).
- ptr  output  ADDR_W  current internal pointer value.
- full  output  1  one-cycle pulse after the pointer wraps.

Behaviour:
- Reset: rst=1 at a rising edge sets q=0, ptr=0, full=0. rst has priority over every other input, including mid-sequence.
- Select: sel = auto_inc ? ptr : a. Evaluated combinationally from the values present at the edge.
- Mode table, evaluated each rising edge when rst=0:
  - g_n=1, clr_n=1: MEMORY. q holds.
  - g_n=0, clr_n=1: ADDRESSABLE LATCH. q[sel] <= d; all other bits hold.
  - g_n=1, clr_n=0: CLEAR. q <= 0.
  - g_n=0, clr_n=0: DEMUX. q <= 0, except q[sel] <= d (one-hot when d=1, all-zero when d=0).
- Latency: one clock. q reflects a write on the cycle after the edge. There is no combinational path from inputs to q.
- Pointer write event: wr = (g_n==0) && auto_inc.
  - wr=1 and ptr != WIDTH-1: ptr <= ptr+1 after the write.
  - wr=1 and ptr == WIDTH-1: ptr <= 0 (wrap) and full <= 1 for exactly one cycle.
  - Otherwise full <= 0.
- auto_inc=0: ptr holds and `a` is used. ptr is not disturbed by externally addressed writes.
- CLEAR mode (g_n=1, clr_n=0) also sets ptr <= 0 and full <= 0.
- DEMUX mode with auto_inc=1 uses ptr, then increments it the same as a latch write. It does not reset ptr.
- Toggling auto_inc mid-sequence: takes effect on the next edge. ptr retains its value.
- Pointer arithmetic is ADDR_W bits, modulo WIDTH. Overflow must not propagate into any other state.
- No X on outputs after the first reset edge. The bench drives rst for at least 1 cycle at time 0.

Test Plan:
1. Reset: rst=1 for 2 cycles with g_n=0, d=1, a=5 → q=8'h00, ptr=0, full=0. Then rst=0, g_n=1, clr_n=1 → q stays 8'h00.
2. Addressable latch: auto_inc=0, clr_n=1, g_n=0. Write d=1 to a=0, then a=3, then a=7, then d=0 to a=3 → q=8'h01, 8'h09, 8'h89, 8'h81 on successive cycles; ptr stays 0.
3. Demux: q preloaded 8'hFF. Drive g_n=0, clr_n=0, a=2, d=1 → q=8'h04. Next cycle d=0, a=6 → q=8'h00.
4. Clear and memory: q=8'hA5, g_n=1, clr_n=0 for one cycle → q=8'h00, ptr=0. Then g_n=1, clr_n=1 with `a` and d toggling randomly → q holds 8'h00.
5. Auto-increment serial load: auto_inc=1, g_n=0, clr_n=1, d stream 1,0,1,1,0,0,1,0 over 8 cycles → q=8'h4D.
   - ptr steps 1..7 then 0.
   - full=1 only in the cycle after the 8th write.
   - A 9th write d=0 clears q[0], giving q=8'h4C, ptr=1.
6. Reset mid-sequence: during test 5 after 4 writes (ptr=4, q=8'h0D), assert rst=1 for 1 cycle → q=8'h00, ptr=0, full=0. Resuming writes starts again at q[0].
